prm_edge_mask_engine: RTL and testbench

Programmable, sequential successor to the hardwired per-table obstacle-logic checks in the PRM truth-table flow. Stores up to TERMS sum-of-products cubes (care mask + value) over an IN_W-bit configuration code. Scans the cubes LANES at a time and returns the registered edge_mask for each queried code over a valid/ready handshake. Sits between the roadmap edge generator and the collision-result buffer, so new obstacle tables load at run time instead of needing new RTL.

---
 rtl/prm_edge_mask_engine.sv | 143 ++++++++++++++
 tb/tb_prm_edge_mask_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_mask_engine.sv
// Programmable sum-of-products edge-mask engine: scans stored cubes LANES per cycle per query.
// Optional build macro PRM_EARLY_EXIT_EN: finish the scan on the first beat that contains a hit.
module prm_edge_mask_engine #(
    parameter int unsigned IN_W  = 15,
    parameter int unsigned TERMS = 128,
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 8,
    localparam int unsigned CW   = $clog2(TERMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_addr,
    input  logic [IN_W-1:0]  cfg_care,
    input  logic [IN_W-1:0]  cfg_val,
    input  logic             cfg_cnt_we,
    input  logic [CW:0]      cfg_cnt,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [IN_W-1:0]  q_code,
    input  logic [TAG_W-1:0] q_tag,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_mask,
    output logic [TAG_W-1:0] r_tag,
    output logic [CW-1:0]    r_hit_idx,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t          r_state;
    logic [IN_W-1:0] r_care [TERMS];
    logic [IN_W-1:0] r_val  [TERMS];
    logic [CW:0]     r_term_cnt;
    logic [CW:0]     r_ptr;
    logic [IN_W-1:0] r_code;

    logic            w_cfg_ok;
    logic [CW:0]     w_cnt_sat;
    logic [CW:0]     w_cnt_eff;
    logic [CW:0]     w_ptr_next;
    logic [CW:0]     w_lane_idx [LANES];
    logic [LANES-1:0] w_lane_hit;
    logic            w_hit_any;
    logic [CW-1:0]   w_hit_idx;
    logic            w_last;
    logic            w_exit;

    assign w_cfg_ok   = (r_state == S_IDLE);
    assign w_cnt_sat  = (cfg_cnt > (CW+1)'(TERMS)) ? (CW+1)'(TERMS) : cfg_cnt;
    // A count written in the accepting cycle already governs that query.
    assign w_cnt_eff  = (w_cfg_ok && cfg_cnt_we) ? w_cnt_sat : r_term_cnt;
    assign w_ptr_next = r_ptr + (CW+1)'(LANES);
    assign w_last     = (w_ptr_next >= r_term_cnt);

    // Cube storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_cfg_ok && cfg_we) begin
            r_care[cfg_addr] <= cfg_care;
            r_val[cfg_addr]  <= cfg_val;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lane_idx[g] = r_ptr + (CW+1)'(g);
        assign w_lane_hit[g] = (w_lane_idx[g] < r_term_cnt) &&
            (((r_code ^ r_val[w_lane_idx[g][CW-1:0]]) & r_care[w_lane_idx[g][CW-1:0]]) == '0);
    end

    // Lowest hitting lane of the current beat.
    always_comb begin
        w_hit_any = |w_lane_hit;
        w_hit_idx = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (w_lane_hit[l]) begin
                w_hit_idx = w_lane_idx[l][CW-1:0];
            end
        end
    end

`ifdef PRM_EARLY_EXIT_EN
    assign w_exit = w_last || w_hit_any;
`else
    assign w_exit = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_term_cnt <= '0;
            r_ptr      <= '0;
            r_code     <= '0;
            q_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_mask     <= 1'b0;
            r_tag      <= '0;
            r_hit_idx  <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_cnt_we) begin
                        r_term_cnt <= w_cnt_sat;
                    end
                    if (q_ready && q_valid) begin
                        q_ready   <= 1'b0;
                        busy      <= 1'b1;
                        r_code    <= q_code;
                        r_tag     <= q_tag;
                        r_mask    <= 1'b0;
                        r_hit_idx <= '0;
                        r_ptr     <= '0;
                        r_state   <= (w_cnt_eff != '0) ? S_SCAN : S_DONE;
                    end else begin
                        q_ready <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_hit_any && !r_mask) begin
                        r_mask    <= 1'b1;
                        r_hit_idx <= w_hit_idx;
                    end
                    r_ptr <= w_ptr_next;
                    if (w_exit) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_valid && r_ready) begin
                        r_valid <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Self-checking bench for prm_edge_mask_engine: directed cases plus random cubes/queries vs. a reference model.
module tb_prm_edge_mask_engine;

    localparam int unsigned IN_W  = 15;
    localparam int unsigned TERMS = 128;
    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned CW    = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we, cfg_cnt_we, q_valid, r_ready;
    logic [CW-1:0]    cfg_addr;
    logic [IN_W-1:0]  cfg_care, cfg_val, q_code;
    logic [CW:0]      cfg_cnt;
    logic [TAG_W-1:0] q_tag, r_tag;
    logic             q_ready, r_valid, r_mask, busy;
    logic [CW-1:0]    r_hit_idx;

    logic [IN_W-1:0]  m_care [TERMS];
    logic [IN_W-1:0]  m_val  [TERMS];
    int               m_cnt;
    int               n_vec = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    prm_edge_mask_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val),
        .cfg_cnt_we(cfg_cnt_we), .cfg_cnt(cfg_cnt),
        .q_valid(q_valid), .q_ready(q_ready), .q_code(q_code), .q_tag(q_tag),
        .r_valid(r_valid), .r_ready(r_ready), .r_mask(r_mask), .r_tag(r_tag),
        .r_hit_idx(r_hit_idx), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: first matching cube among the active count, beats = ceil(cnt/LANES).
    task automatic ref_q(input logic [IN_W-1:0] code, output bit mask, output int idx, output int lat);
        int beats;
        mask = 0;
        idx  = 0;
        for (int i = 0; i < m_cnt; i++) begin
            if (!mask && ((code ^ m_val[i]) & m_care[i]) == 0) begin
                mask = 1;
                idx  = i;
            end
        end
        beats = (m_cnt + LANES - 1) / LANES;
`ifdef PRM_EARLY_EXIT_EN
        if (mask) beats = idx / LANES + 1;
`endif
        lat = beats + 1;
    endtask

    task automatic load_cube(input int idx, input logic [IN_W-1:0] care, input logic [IN_W-1:0] val);
        cfg_we = 1'b1; cfg_addr = CW'(idx); cfg_care = care; cfg_val = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_care[idx] = care;
        m_val[idx]  = val;
    endtask

    task automatic set_cnt(input int cnt);
        cfg_cnt_we = 1'b1; cfg_cnt = (CW+1)'(cnt);
        @(posedge clk); #1;
        cfg_cnt_we = 1'b0;
        m_cnt = (cnt > TERMS) ? TERMS : cnt;
    endtask

    task automatic check_query(input logic [IN_W-1:0] code, input logic [TAG_W-1:0] tag,
                               input int hold, input bit busy_wr, input string nm);
        bit em;
        int ei, el, lat, n;
        ref_q(code, em, ei, el);
        n = 0;
        while (!q_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_q_ready"}, 32'(q_ready), 32'd1);
        q_valid = 1'b1; q_code = code; q_tag = tag;
        @(posedge clk); #1;
        q_valid = 1'b0;
        lat = 0;
        do begin
            if (busy_wr && lat == 0) begin
                cfg_we = 1'b1; cfg_addr = CW'(8); cfg_care = 15'h7FFF; cfg_val = 15'h1234;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            lat++;
        end while (!r_valid && lat < 300);
        chk({nm, "_latency"}, 32'(lat), 32'(el));
        chk({nm, "_mask"}, 32'(r_mask), 32'(em));
        chk({nm, "_hit_idx"}, 32'(r_hit_idx), 32'(ei));
        chk({nm, "_tag"}, 32'(r_tag), 32'(tag));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 32'(r_valid), 32'd1);
            chk({nm, "_hold_mask"}, 32'(r_mask), 32'(em));
            chk({nm, "_hold_tag"}, 32'(r_tag), 32'(tag));
            chk({nm, "_hold_q_ready"}, 32'(q_ready), 32'd0);
        end
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        chk({nm, "_valid_clear"}, 32'(r_valid), 32'd0);
    endtask

    initial begin
        logic [IN_W-1:0] code;
        int j;
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_cnt_we = 1'b0; q_valid = 1'b0; r_ready = 1'b0;
        cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_cnt = '0; q_code = '0; q_tag = '0;
        m_cnt = 0;
        for (int i = 0; i < TERMS; i++) begin
            m_care[i] = '0;
            m_val[i]  = '0;
        end
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_q_ready", 32'(q_ready), 32'd1);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_mask", 32'(r_mask), 32'd0);
        chk("rst_r_tag", 32'(r_tag), 32'd0);
        chk("rst_r_hit_idx", 32'(r_hit_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        check_query(15'h1234, 8'h11, 0, 0, "empty");

        load_cube(0, 15'h6000, 15'h4000);
        set_cnt(1);
        check_query(15'h4ABC, 8'h21, 0, 0, "one_hit");
        check_query(15'h2ABC, 8'h22, 0, 0, "one_miss");

        for (int i = 0; i < 8; i++) load_cube(i, 15'h7FFF, 15'h7FFF);
        load_cube(8, 15'h7FFF, 15'h0001);
        set_cnt(9);
        check_query(15'h0001, 8'h31, 0, 0, "last_cube");

        load_cube(2, 15'h0000, 15'h0000);
        load_cube(5, 15'h0000, 15'h0000);
        check_query(15'h0001, 8'h41, 0, 0, "lowest_hit");

        load_cube(2, 15'h7FFF, 15'h7FFF);
        load_cube(5, 15'h7FFF, 15'h7FFF);
        check_query(15'h0001, 8'h51, 5, 1, "hold_busy_wr");
        check_query(15'h0001, 8'h52, 0, 0, "after_drop");

        // Random cubes and queries; some codes are derived from an active cube to force hits.
        for (int i = 0; i < TERMS; i++)
            load_cube(i, 15'($urandom) | 15'($urandom), 15'($urandom));
        for (int t = 0; t < 40; t++) begin
            if (t % 5 == 0) set_cnt($urandom_range(0, 160));
            if (m_cnt > 0 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, m_cnt - 1);
                code = m_val[j] ^ (15'($urandom) & ~m_care[j]);
            end else begin
                code = 15'($urandom);
            end
            check_query(code, 8'($urandom), t % 3, 0, "rand");
        end

        set_cnt(9);
        while (!q_ready) begin
            @(posedge clk); #1;
        end
        q_valid = 1'b1; q_code = 15'h0001; q_tag = 8'h77;
        @(posedge clk); #1;
        q_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_q_ready", 32'(q_ready), 32'd1);
        chk("abort_r_valid", 32'(r_valid), 32'd0);
        chk("abort_r_tag", 32'(r_tag), 32'd0);
        chk("abort_r_mask", 32'(r_mask), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        #3 rst_n = 1'b1;
        m_cnt = 0;
        @(posedge clk); #1;
        check_query(15'h0001, 8'h78, 0, 0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
